// File: rtl/dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_bridge: MEM-stage load/store to req/ack data-bus bridge with byte   |
// | lane steering and load extension. Option: DMEM_ALIGN_CHECK_EN. Rev 1.0   |
// +--------------------------------------------------------------------------+
module dmem_bridge #(
  parameter int          W              = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  input  logic [1:0]   mem_size,
  input  logic         load_unsigned,
  output logic         stall,
  output logic         bus_req,
  output logic         bus_we,
  output logic [W-1:0] bus_addr,
  output logic [W-1:0] bus_wdata,
  output logic [3:0]   bus_be,
  input  logic         bus_ack,
  input  logic [W-1:0] bus_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic         misalign,
`endif
  output logic         bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  state_t       state;
  state_t       state_next;
  logic         req_any;
  logic [W-1:0] addr_sel;
  logic         misal_hit;
  logic         start;
  logic         ack_hit;
  logic         to_hit;
  logic [1:0]   lat_off;
  logic [1:0]   lat_size;
  logic         lat_uns;
  logic         lat_load;
  logic [31:0]  to_cnt;
  logic [3:0]   be_calc;
  logic [W-1:0] wdata_calc;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic [W-1:0] rdata_fmt;

  // Store wins when both requests are present in the same cycle.
  assign req_any  = load_en | store_en;
  assign addr_sel = store_en ? s_addr : l_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic addr_bad;

  always_comb begin
    case (mem_size)
      2'b00:   addr_bad = 1'b0;
      2'b01:   addr_bad = addr_sel[0];
      default: addr_bad = |addr_sel[1:0];
    endcase
  end

  assign misal_hit = rst_n && (state == ST_IDLE) && req_any && addr_bad;
  assign misalign  = misal_hit;
`else
  assign misal_hit = 1'b0;
`endif

  always_comb begin
    case (mem_size)
      2'b00: begin
        be_calc    = 4'b0001 << addr_sel[1:0];
        wdata_calc = {4{s_data[7:0]}};
      end
      2'b01: begin
        be_calc    = addr_sel[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{s_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = s_data;
      end
    endcase
  end

  always_comb begin
    case (lat_off)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lat_size)
      2'b00:   rdata_fmt = {{24{lane_b[7] & ~lat_uns}}, lane_b};
      2'b01:   rdata_fmt = {{16{lane_h[15] & ~lat_uns}}, lane_h};
      default: rdata_fmt = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    ack_hit    = 1'b0;
    to_hit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_any && !misal_hit) begin
          stall      = 1'b1;
          start      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        // An ack in the final allowed cycle still completes normally.
        if (bus_ack) begin
          ack_hit    = 1'b1;
          state_next = ST_DONE;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          to_hit     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= 4'b0000;
      l_data    <= '0;
      bus_err   <= 1'b0;
      lat_off   <= 2'b00;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_load  <= 1'b0;
      to_cnt    <= '0;
    end else begin
      bus_err <= 1'b0;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= store_en;
        bus_addr  <= {addr_sel[W-1:2], 2'b00};
        bus_wdata <= wdata_calc;
        bus_be    <= be_calc;
        lat_off   <= addr_sel[1:0];
        lat_size  <= mem_size;
        lat_uns   <= load_unsigned;
        lat_load  <= !store_en;
        to_cnt    <= '0;
      end else if (state == ST_REQ) begin
        to_cnt <= to_cnt + 32'd1;
        if (ack_hit) begin
          bus_req <= 1'b0;
          if (lat_load) begin
            l_data <= rdata_fmt;
          end
        end else if (to_hit) begin
          bus_req <= 1'b0;
          bus_err <= 1'b1;
          l_data  <= '0;
        end
      end
      if (misal_hit) begin
        l_data <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_bridge: self-checking bench, one wait-forever and one            |
// | TIMEOUT_CYCLES=4 instance driven in lockstep. Rev 1.0                    |
// +--------------------------------------------------------------------------+
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en, store_en, load_unsigned, bus_ack;
  logic [31:0] l_addr, s_addr, s_data, bus_rdata;
  logic [1:0]  mem_size;

  logic [31:0] l_data0, l_data4, bus_addr0, bus_addr4, bus_wdata0, bus_wdata4;
  logic        stall0, stall4, bus_req0, bus_req4, bus_we0, bus_we4;
  logic        bus_err0, bus_err4;
  logic [3:0]  bus_be0, bus_be4;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign0, misalign4;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_ld;

  always #5 clk = ~clk;

  dmem_bridge #(.W(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .l_addr(l_addr), .l_data(l_data0),
    .store_en(store_en), .s_addr(s_addr), .s_data(s_data), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .stall(stall0), .bus_req(bus_req0), .bus_we(bus_we0),
    .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_be(bus_be0), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .misalign(misalign0),
`endif
    .bus_err(bus_err0));

  dmem_bridge #(.W(32), .TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .l_addr(l_addr), .l_data(l_data4),
    .store_en(store_en), .s_addr(s_addr), .s_data(s_data), .mem_size(mem_size),
    .load_unsigned(load_unsigned), .stall(stall4), .bus_req(bus_req4), .bus_we(bus_we4),
    .bus_addr(bus_addr4), .bus_wdata(bus_wdata4), .bus_be(bus_be4), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .misalign(misalign4),
`endif
    .bus_err(bus_err4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk2(input string nm, input logic [31:0] a0, input logic [31:0] a4,
                      input logic [31:0] exp);
    chk({nm, "/to0"}, a0, exp);
    chk({nm, "/to4"}, a4, exp);
  endtask

  // Reference model, written from the lane/extension rules with arithmetic.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    int n;
    if (sz == 2'd0) n = 1 << (a % 4);
    else if (sz == 2'd1) n = 3 << (2 * ((a / 2) % 2));
    else n = 15;
    return 4'(n);
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_txn(input logic st, input logic ld, input logic [31:0] sa,
                         input logic [31:0] la, input logic [31:0] sd, input logic [1:0] sz,
                         input logic uns, input int ackd, input logic [31:0] rd,
                         input logic [31:0] e_baddr, input logic [31:0] e_wd,
                         input logic [3:0] e_be, input logic e_mis, input logic [31:0] e_ld);
    store_en = st; load_en = ld; s_addr = sa; l_addr = la; s_data = sd;
    mem_size = sz; load_unsigned = uns; bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
`ifdef DMEM_ALIGN_CHECK_EN
    chk2("misalign", 32'(misalign0), 32'(misalign4), 32'(e_mis));
`endif
    chk2("stall_idle", 32'(stall0), 32'(stall4), 32'(!e_mis));
    if (e_mis) begin
      tick();
      chk2("req_mis", 32'(bus_req0), 32'(bus_req4), 32'd0);
      chk2("ldata_mis", l_data0, l_data4, e_ld);
      store_en = 1'b0; load_en = 1'b0;
      return;
    end
    tick();
    chk2("req_start", 32'(bus_req0), 32'(bus_req4), 32'd1);
    chk2("we", 32'(bus_we0), 32'(bus_we4), 32'(st));
    chk2("baddr", bus_addr0, bus_addr4, e_baddr);
    chk2("be", 32'(bus_be0), 32'(bus_be4), 32'(e_be));
    if (st) chk2("wdata", bus_wdata0, bus_wdata4, e_wd);
    for (int k = 1; k <= ackd; k++) begin
      bus_ack   = (k == ackd);
      bus_rdata = (k == ackd) ? rd : $urandom;
      #1;
      chk2("stall_req", 32'(stall0), 32'(stall4), 32'd1);
      chk2("req_hold", 32'(bus_req0), 32'(bus_req4), 32'd1);
      chk2("baddr_hold", bus_addr0, bus_addr4, e_baddr);
      tick();
    end
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    #1;
    chk2("req_done", 32'(bus_req0), 32'(bus_req4), 32'd0);
    chk2("stall_done", 32'(stall0), 32'(stall4), 32'd0);
    chk2("ldata", l_data0, l_data4, e_ld);
    chk2("err_done", 32'(bus_err0), 32'(bus_err4), 32'd0);
    tick();
    store_en = 1'b0; load_en = 1'b0; bus_ack = 1'b0;
    #1;
    chk2("ldata_after", l_data0, l_data4, e_ld);
    chk2("stall_after", 32'(stall0), 32'(stall4), 32'd0);
  endtask

  typedef struct {
    logic        st, ld;
    logic [31:0] sa, la, sd;
    logic [1:0]  sz;
    logic        uns;
    int          ackd;
    logic [31:0] rd, e_baddr, e_wd;
    logic [3:0]  e_be;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           st   ld   sa        la        sd            sz  uns ackd rd            baddr     wd            be       ld
    tbl[0]  = '{1'b1,1'b0,32'h100, 32'h0,   32'hDEADBEEF,2'd2,1'b0,2,32'h0,       32'h100,32'hDEADBEEF,4'b1111,32'h0};
    tbl[1]  = '{1'b0,1'b1,32'h0,   32'h103, 32'h0,       2'd0,1'b0,1,32'h80FF0000,32'h100,32'h0,       4'b1000,32'hFFFFFF80};
    tbl[2]  = '{1'b0,1'b1,32'h0,   32'h103, 32'h0,       2'd0,1'b1,1,32'h80FF0000,32'h100,32'h0,       4'b1000,32'h00000080};
    tbl[3]  = '{1'b0,1'b1,32'h0,   32'h102, 32'h0,       2'd1,1'b1,1,32'h80FF0000,32'h100,32'h0,       4'b1100,32'h000080FF};
    tbl[4]  = '{1'b1,1'b0,32'h102, 32'h0,   32'h1234ABCD,2'd1,1'b0,1,32'h0,       32'h100,32'hABCDABCD,4'b1100,32'h000080FF};
    tbl[5]  = '{1'b0,1'b1,32'h0,   32'h200, 32'h0,       2'd1,1'b0,2,32'h1234F00D,32'h200,32'h0,       4'b0011,32'hFFFFF00D};
    tbl[6]  = '{1'b1,1'b0,32'h101, 32'h0,   32'h000000A5,2'd0,1'b0,1,32'h0,       32'h100,32'hA5A5A5A5,4'b0010,32'hFFFFF00D};
    tbl[7]  = '{1'b0,1'b1,32'h0,   32'h204, 32'h0,       2'd2,1'b0,3,32'hCAFEF00D,32'h204,32'h0,       4'b1111,32'hCAFEF00D};
    tbl[8]  = '{1'b1,1'b1,32'h300, 32'h400, 32'h11223344,2'd2,1'b0,1,32'hFFFFFFFF,32'h300,32'h11223344,4'b1111,32'hCAFEF00D};
    tbl[9]  = '{1'b0,1'b1,32'h0,   32'h10,  32'h0,       2'd3,1'b0,1,32'h89ABCDEF,32'h010,32'h0,       4'b1111,32'h89ABCDEF};
    tbl[10] = '{1'b0,1'b1,32'h0,   32'h202, 32'h0,       2'd1,1'b0,4,32'h7FFF8000,32'h200,32'h0,       4'b1100,32'h00007FFF};
    tbl[11] = '{1'b0,1'b1,32'h0,   32'h101, 32'h0,       2'd0,1'b0,1,32'h00007F00,32'h100,32'h0,       4'b0010,32'h0000007F};

    rst_n = 1'b0; load_en = 1'b0; store_en = 1'b0; l_addr = '0; s_addr = '0; s_data = '0;
    mem_size = 2'd0; load_unsigned = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk2("rst_req", 32'(bus_req0), 32'(bus_req4), 32'd0);
    chk2("rst_we", 32'(bus_we0), 32'(bus_we4), 32'd0);
    chk2("rst_addr", bus_addr0, bus_addr4, 32'd0);
    chk2("rst_wdata", bus_wdata0, bus_wdata4, 32'd0);
    chk2("rst_be", 32'(bus_be0), 32'(bus_be4), 32'd0);
    chk2("rst_ldata", l_data0, l_data4, 32'd0);
    chk2("rst_err", 32'(bus_err0), 32'(bus_err4), 32'd0);
    chk2("rst_stall", 32'(stall0), 32'(stall4), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_txn(tbl[i].st, tbl[i].ld, tbl[i].sa, tbl[i].la, tbl[i].sd, tbl[i].sz, tbl[i].uns,
              tbl[i].ackd, tbl[i].rd, tbl[i].e_baddr, tbl[i].e_wd, tbl[i].e_be, 1'b0,
              tbl[i].e_ld);

    // Reset while a request is outstanding, then a late ack.
    load_en = 1'b1; l_addr = 32'h500; mem_size = 2'd2; load_unsigned = 1'b0;
    tick();
    chk2("abort_req_pre", 32'(bus_req0), 32'(bus_req4), 32'd1);
    rst_n = 1'b0; load_en = 1'b0;
    tick();
    chk2("abort_req", 32'(bus_req0), 32'(bus_req4), 32'd0);
    chk2("abort_stall", 32'(stall0), 32'(stall4), 32'd0);
    rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    tick();
    bus_ack = 1'b0;
    chk2("late_ack_ldata", l_data0, l_data4, 32'd0);
    chk2("late_ack_req", 32'(bus_req0), 32'(bus_req4), 32'd0);
    cur_ld = 32'd0;

    // Misaligned word load.
`ifdef DMEM_ALIGN_CHECK_EN
    run_txn(1'b0, 1'b1, 32'h0, 32'h102, 32'h0, 2'd2, 1'b0, 1, 32'h55AA55AA,
            32'h100, 32'h0, 4'b1111, 1'b1, 32'h0);
    cur_ld = 32'h0;
`else
    run_txn(1'b0, 1'b1, 32'h0, 32'h102, 32'h0, 2'd2, 1'b0, 1, 32'h55AA55AA,
            32'h100, 32'h0, 4'b1111, 1'b0, 32'h55AA55AA);
    cur_ld = 32'h55AA55AA;
`endif

    // Timeout on the TIMEOUT_CYCLES=4 instance; the other keeps waiting.
    load_en = 1'b1; l_addr = 32'h600; mem_size = 2'd2; bus_ack = 1'b0;
    #1;
    chk2("to_stall_idle", 32'(stall0), 32'(stall4), 32'd1);
    tick();
    load_en = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("to_req4", 32'(bus_req4), 32'd1);
      chk("to_err4_low", 32'(bus_err4), 32'd0);
      chk("to_stall4", 32'(stall4), 32'd1);
      chk("to_req0", 32'(bus_req0), 32'd1);
      tick();
    end
    chk("to_err4", 32'(bus_err4), 32'd1);
    chk("to_req4_drop", 32'(bus_req4), 32'd0);
    chk("to_stall4_drop", 32'(stall4), 32'd0);
    chk("to_ldata4", l_data4, 32'd0);
    chk("to_req0_wait", 32'(bus_req0), 32'd1);
    chk("to_stall0_wait", 32'(stall0), 32'd1);
    chk("to_err0", 32'(bus_err0), 32'd0);
    tick();
    chk("to_err4_pulse", 32'(bus_err4), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
    tick();
    bus_ack = 1'b0;
    chk("wait_ldata0", l_data0, 32'h13579BDF);
    chk("wait_req0", 32'(bus_req0), 32'd0);
    chk("late_ldata4", l_data4, 32'd0);
    tick();

    // Resynchronise l_data on both instances.
    run_txn(1'b0, 1'b1, 32'h0, 32'h700, 32'h0, 2'd2, 1'b0, 1, 32'h0BADCAFE,
            32'h700, 32'h0, 4'b1111, 1'b0, 32'h0BADCAFE);
    cur_ld = 32'h0BADCAFE;

    for (int i = 0; i < 150; i++) begin
      logic        st, ld, uns, mis;
      logic [1:0]  sz;
      logic [31:0] sa, la, sd, rd, a, e_ld;
      int          op, ackd;
      op   = $urandom_range(0, 5);
      st   = (op >= 3);
      ld   = (op <= 2) || (op == 5);
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      sa   = $urandom & 32'h0000FFFF;
      la   = $urandom & 32'h0000FFFF;
      sd   = $urandom;
      rd   = $urandom;
      ackd = $urandom_range(1, 4);
      a    = st ? sa : la;
      mis  = m_mis(a, sz);
      if (mis) e_ld = 32'h0;
      else if (st) e_ld = cur_ld;
      else e_ld = m_load(rd, a, sz, uns);
      run_txn(st, ld, sa, la, sd, sz, uns, ackd, rd, a & 32'hFFFFFFFC, m_wd(sd, sz),
              m_be(a, sz), mis, e_ld);
      cur_ld = e_ld;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
